// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect bundle between pipe_ctrl and the pipeline it steers.
// Latency: none (wires only); backpressure: stall_o/flush_o are the backpressure into the stage registers.
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    logic        ld_use_i;
    logic        div_start_i;
    logic        istall_req_i;
    logic        dstall_req_i;
    logic        except_i;
    logic [31:0] target_pc_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        div_ready_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;
`endif

    modport slave (
        input  ld_use_i, div_start_i, istall_req_i, dstall_req_i, except_i, target_pc_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, div_ready_o
`ifdef PIPE_CTRL_PERF_EN
        , output stall_cycles_o, flush_count_o
`endif
    );

    modport master (
        output ld_use_i, div_start_i, istall_req_i, dstall_req_i, except_i, target_pc_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, div_ready_o
`ifdef PIPE_CTRL_PERF_EN
        , input stall_cycles_o, flush_count_o
`endif
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Prioritised stall/flush/redirect scheduler for the 5-stage pipeline (divider, cache freeze, precise exceptions).
// Latency: stall/flush/redirect are combinational (same edge); divide releases DIV_CYCLES cycles after start.
// Backpressure: holds PC..MEM2WB via stall_o; optional PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 36
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV      = 2'd1,
        ST_EXC_WAIT = 2'd2
    } state_e;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    logic        in_wait;
    logic        redir_take;
    logic        exc_block;
    logic        freeze;
    logic        div_busy;
    logic        div_done;

    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        div_ready;

    assign in_wait    = (state_q == ST_EXC_WAIT);
    // In EXC_WAIT the latched exception fires as soon as memory goes quiet.
    assign redir_take = in_wait ? !bus.dstall_req_i : (bus.except_i && !bus.dstall_req_i);
    assign exc_block  = !in_wait && bus.except_i && bus.dstall_req_i;
    assign freeze     = bus.istall_req_i || bus.dstall_req_i || in_wait;
    assign div_busy   = ((state_q == ST_DIV) && (div_cnt_q != 6'd0)) ||
                        ((state_q == ST_RUN) && bus.div_start_i);
    assign div_done   = (state_q == ST_DIV) && (div_cnt_q == 6'd0) && !freeze && !bus.except_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            div_cnt_q <= 6'd0;
            exc_pc_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            exc_pc_q  <= exc_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        exc_pc_d  = exc_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (redir_take) begin
                    state_d   = ST_RUN;
                    div_cnt_d = 6'd0;
                end else if (exc_block) begin
                    state_d  = ST_EXC_WAIT;
                    exc_pc_d = bus.target_pc_i;
                end else if (bus.div_start_i) begin
                    state_d   = ST_DIV;
                    div_cnt_d = DIV_LOAD;
                end
            end
            ST_DIV: begin
                if (redir_take) begin
                    state_d   = ST_RUN;
                    div_cnt_d = 6'd0;
                end else if (exc_block) begin
                    state_d   = ST_EXC_WAIT;
                    div_cnt_d = 6'd0;
                    exc_pc_d  = bus.target_pc_i;
                end else if (div_done) begin
                    state_d = ST_RUN;
                end else begin
                    // Divider is free-running: count through freezes, park at zero.
                    div_cnt_d = (div_cnt_q != 6'd0) ? div_cnt_q - 6'd1 : 6'd0;
                end
            end
            ST_EXC_WAIT: begin
                if (!bus.dstall_req_i) begin
                    state_d   = ST_RUN;
                    div_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d   = ST_RUN;
                div_cnt_d = 6'd0;
            end
        endcase
    end

    always_comb begin
        stall       = 5'b00000;
        flush       = 5'b00000;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        div_ready   = 1'b0;
        if (!rst_i) begin
            flush = 5'b11110;
        end else if (redir_take) begin
            flush       = 5'b11110;
            redirect    = 1'b1;
            redirect_pc = in_wait ? exc_pc_q : bus.target_pc_i;
        end else if (exc_block || freeze) begin
            stall = 5'b11111;
        end else if (div_busy) begin
            stall = 5'b00111;
            flush = 5'b01000;
        end else begin
            div_ready = div_done;
            if (bus.ld_use_i) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.redirect_o    = redirect;
    assign bus.redirect_pc_o = redirect_pc;
    assign bus.div_ready_o   = div_ready;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (stall[0]) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (redirect) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles_o = stall_cycles_q;
    assign bus.flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DIV_CYCLES=8; expected outputs queued per step.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
    } obs_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DIV_CYCLES(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    function automatic obs_t mk(input logic [4:0] s, input logic [4:0] f, input logic r,
                                input logic [31:0] pc, input logic d);
        obs_t o;
        o.stall = s; o.flush = f; o.redir = r; o.rpc = pc; o.rdy = d;
        return o;
    endfunction

    task automatic compare(input string tag);
        obs_t o;
        obs_t x;
        o = mk(bus.stall_o, bus.flush_o, bus.redirect_o, bus.redirect_pc_o, bus.div_ready_o);
        x = exp_q.pop_front();
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic drive(input logic ld, input logic dv, input logic is, input logic ds,
                         input logic ex, input logic [31:0] tpc);
        bus.ld_use_i     = ld;
        bus.div_start_i  = dv;
        bus.istall_req_i = is;
        bus.dstall_req_i = ds;
        bus.except_i     = ex;
        bus.target_pc_i  = tpc;
    endtask

    // Drive at posedge+1, check at the following negedge, return at next posedge+1.
    task automatic step(input string tag, input logic ld, input logic dv, input logic is,
                        input logic ds, input logic ex, input logic [31:0] tpc, input obs_t e);
        drive(ld, dv, is, ds, ex, tpc);
        exp_q.push_back(e);
        @(negedge clk_i);
        compare(tag);
        @(posedge clk_i);
        #1;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic check_perf(input string tag, input logic [31:0] sc, input logic [31:0] fc);
        checks++;
        assert (bus.stall_cycles_o === sc && bus.flush_count_o === fc) else begin
            errors++;
            $error("FAIL %s: observed=%h/%h expected=%h/%h", tag,
                   bus.stall_cycles_o, bus.flush_count_o, sc, fc);
        end
    endtask
`endif

    localparam logic [4:0] S_DIV = 5'b00111;
    localparam logic [4:0] F_DIV = 5'b01000;
    localparam logic [4:0] S_ALL = 5'b11111;
    localparam logic [4:0] F_RED = 5'b11110;

    initial begin
        obs_t idle;
        obs_t rst_v;
        obs_t dstl;
        obs_t frz;
        idle  = mk(5'b0, 5'b0, 1'b0, 32'd0, 1'b0);
        rst_v = mk(5'b0, F_RED, 1'b0, 32'd0, 1'b0);
        dstl  = mk(S_DIV, F_DIV, 1'b0, 32'd0, 1'b0);
        frz   = mk(S_ALL, 5'b0, 1'b0, 32'd0, 1'b0);

        // Reset value overrides active inputs.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        exp_q.push_back(rst_v);
        compare("reset");
`ifdef PIPE_CTRL_PERF_EN
        check_perf("perf_reset", 32'd0, 32'd0);
`endif
        rst_i = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Load-use: single bubble.
        step("ld_use", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(5'b00011, 5'b00100, 1'b0, 32'd0, 1'b0));
        step("ld_use_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Plain divide: 8 stall cycles then ready; ld_use masked mid-divide.
        step("div_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        for (int i = 1; i <= 7; i++)
            step($sformatf("div_stall%0d", i), (i == 3), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        step("div_ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(5'b0, 5'b0, 1'b0, 32'd0, 1'b1));
        step("div_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Freeze inside divide: dstall over cycles 6..12, ready in 13.
        step("fz_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        for (int i = 1; i <= 5; i++)
            step($sformatf("fz_div%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        for (int i = 6; i <= 12; i++)
            step($sformatf("fz_frz%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, frz);
        step("fz_ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(5'b0, 5'b0, 1'b0, 32'd0, 1'b1));
        step("fz_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Icache freeze outranks load-use.
        step("istall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, frz);
        step("istall_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Exception blocked by memory; later targets ignored.
        step("exb_0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC00380, frz);
        for (int i = 1; i <= 3; i++)
            step($sformatf("exb_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, frz);
        step("exb_redir", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678,
             mk(5'b0, F_RED, 1'b1, 32'hBFC00380, 1'b0));
        step("exb_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        // Exception at divide cycle 3 abandons the divide.
        step("exd_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        step("exd_div1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        step("exd_div2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        step("exd_redir", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000180,
             mk(5'b0, F_RED, 1'b1, 32'h80000180, 1'b0));
        for (int i = 0; i < 8; i++)
            step($sformatf("exd_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);
        step("exd_restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        for (int i = 1; i <= 7; i++)
            step($sformatf("exd_rdiv%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        step("exd_rready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(5'b0, 5'b0, 1'b0, 32'd0, 1'b1));

        // Reset mid-divide: asynchronous reset values, divide lost.
        step("rd_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        for (int i = 1; i <= 3; i++)
            step($sformatf("rd_div%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dstl);
        #2;
        rst_i = 1'b0;
        #1;
        exp_q.push_back(rst_v);
        compare("rd_async_reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        step("rd_idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);
`ifdef PIPE_CTRL_PERF_EN
        check_perf("perf_after_reset", 32'd0, 32'd0);
`endif
        for (int i = 1; i <= 8; i++)
            step($sformatf("rd_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
